// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   state_t       controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH default operand width
//   booth_op_t    radix-2 Booth recoding result (NOP, ADD, SUB)
//   booth_decode  maps {Q[0], q_1} onto a Booth op
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        NOP = 2'b00,
        ADD = 2'b01,
        SUB = 2'b10
    } booth_op_t;

    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// booth_seq_mult_if: pipeline <-> multiply unit handshake and HI/LO access.
//   start/is_signed/a/b    multiply request (pipeline -> unit)
//   hi_we/lo_we/wdata      MTHI/MTLO writes
//   rd_req                 MFHI/MFLO in decode
//   busy/done/stall        sequencer status back to the pipeline
//   hi/lo/of_flag          architectural HI/LO and overflow flag
interface booth_seq_mult_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             rd_req;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             of_flag;

    modport master (
        output start, is_signed, a, b, hi_we, lo_we, wdata, rd_req,
        input  busy, done, stall, hi, lo, of_flag
    );

    modport slave (
        input  start, is_signed, a, b, hi_we, lo_we, wdata, rd_req,
        output busy, done, stall, hi, lo, of_flag
    );
endinterface

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
//   acc, m      accumulator A and multiplicand M (WIDTH+1 bits, signed)
//   q, q_1      multiplier register Q and the appended q_1 bit
//   acc_next, q_next, q_1_next   {A, Q, q_1} after add/sub and arithmetic shift
module booth_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic signed [WIDTH:0] acc,
    input  logic signed [WIDTH:0] m,
    input  logic        [WIDTH:0] q,
    input  logic                  q_1,
    output logic signed [WIDTH:0] acc_next,
    output logic        [WIDTH:0] q_next,
    output logic                  q_1_next
);
    logic signed [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case (booth_decode(q[0], q_1))
            ADD:     sum = acc + m;
            SUB:     sum = acc - m;
            default: sum = acc;
        endcase
        // Arithmetic right shift of {sum, q, q_1}: replicate sum's sign, drop q_1.
        {acc_next, q_next, q_1_next} = {sum[WIDTH], sum, q};
    end
endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: iterative radix-2 Booth multiplier owning HI/LO.
//   clk    system clock (rising edge)
//   rst_n  asynchronous active-low reset
//   bus    slave side of booth_seq_mult_if (start/busy/done handshake,
//          MTHI/MTLO writes, MFHI/MFLO stall, HI/LO/of_flag outputs)
// A product takes WIDTH+1 Booth steps on WIDTH+1-bit operands so that the
// unsigned case is exact; HI/LO take the low 2*WIDTH bits of {A, Q}.
module booth_seq_mult
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    booth_seq_mult_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t                state, state_next;
    logic [CNT_W-1:0]      count;
    logic                  sgn_q;
    logic signed [WIDTH:0] m_q;
    logic signed [WIDTH:0] acc_q, acc_step;
    logic        [WIDTH:0] q_q, q_step;
    logic                  q1_q, q1_step;
    logic [WIDTH-1:0]      hi_q, lo_q, hi_prod, lo_prod;
    logic                  of_q;
    logic                  accept, last_step, mt_ok, busy;

    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v, input logic sgn);
        return {sgn & v[WIDTH-1], v};
    endfunction

    function automatic logic overflow(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l,
                                      input logic sgn);
        return sgn ? (h != {WIDTH{l[WIDTH-1]}}) : (h != '0);
    endfunction

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .m        (m_q),
        .q        (q_q),
        .q_1      (q1_q),
        .acc_next (acc_step),
        .q_next   (q_step),
        .q_1_next (q1_step)
    );

    // Low 2*WIDTH bits of {A, Q} after the final step.
    assign hi_prod = {acc_step[WIDTH-2:0], q_step[WIDTH]};
    assign lo_prod = q_step[WIDTH-1:0];

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        mt_ok      = 1'b0;
        case (state)
            IDLE: begin
                // start takes priority over a same-cycle MTHI/MTLO.
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    mt_ok = 1'b1;
                end
            end
            RUN: begin
                if (count == CNT_W'(WIDTH)) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                mt_ok      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            of_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                count <= '0;
            end else if (state == RUN) begin
                count <= count + 1'b1;
            end
            if (last_step) begin
                hi_q <= hi_prod;
                lo_q <= lo_prod;
                of_q <= overflow(hi_prod, lo_prod, sgn_q);
            end else if (mt_ok) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    // Working registers carry no reset: they are reloaded on every accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            sgn_q <= bus.is_signed;
            m_q   <= ext(bus.a, bus.is_signed);
            acc_q <= '0;
            q_q   <= ext(bus.b, bus.is_signed);
            q1_q  <= 1'b0;
        end else if (state == RUN) begin
            acc_q <= acc_step;
            q_q   <= q_step;
            q1_q  <= q1_step;
        end
    end

    assign busy        = (state == RUN);
    assign bus.busy    = busy;
    assign bus.done    = (state == DONE);
    assign bus.stall   = bus.rd_req & busy;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.of_flag = of_q;
endmodule
